// File: rtl/stack_memory.sv
// rtl/stack_memory.sv - word-addressed stack storage: write port at SP, combinational reads at SP and SP-1
// Optional STACK_BYPASS_EN: forward write_data to the read ports during a write cycle.
module stack_memory #(
  parameter int REG_BITS   = 32,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                StackWrite,
  input  logic [31:0]         SP,
  input  logic [REG_BITS-1:0] write_data,
  output logic [REG_BITS-1:0] read1,
  output logic [REG_BITS-1:0] read2
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;

  logic [REG_BITS-1:0]   mem_q [DEPTH];
  logic [REG_BITS-1:0]   mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] idx1;
  logic [DEPTH_LOG2-1:0] idx2;
  logic                  sp_is_zero;

  // Truncating SP-1 to the index width gives the same entry as a 32-bit subtract.
  assign idx1       = SP[DEPTH_LOG2-1:0];
  assign idx2       = idx1 - IDX_ONE;
  assign sp_is_zero = (SP == 32'd0);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (StackWrite) begin
      mem_d[idx1] = write_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        mem_q[i] <= '0;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

`ifdef STACK_BYPASS_EN
  logic fwd;
  assign fwd = StackWrite && !reset;

  always_comb begin
    read1 = fwd ? write_data : mem_q[idx1];
    if (sp_is_zero) begin
      read2 = '0;
    end else if (fwd && (idx2 == idx1)) begin
      read2 = write_data;
    end else begin
      read2 = mem_q[idx2];
    end
  end
`else
  always_comb begin
    read1 = mem_q[idx1];
    read2 = sp_is_zero ? '0 : mem_q[idx2];
  end
`endif

endmodule

// File: tb/tb_stack_memory.sv
// tb/tb_stack_memory.sv - scoreboard bench for stack_memory
// Stimulus queues expected read values; a negedge monitor pops and compares them.
module tb_stack_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        StackWrite = 1'b0;
  logic [31:0] SP = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read1;
  logic [31:0] read2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    bit          sel2;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];

  stack_memory #(.REG_BITS(32), .DEPTH_LOG2(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .StackWrite (StackWrite),
    .SP         (SP),
    .write_data (write_data),
    .read1      (read1),
    .read2      (read2)
  );

  always #5 clk = ~clk;

  // Monitor: read ports are combinational, so they are valid every negedge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb_q.pop_front();
      act = e.sel2 ? read2 : read1;
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
      end
    end
  end

  task automatic cyc(input logic rst, input logic we, input logic [31:0] sp, input logic [31:0] wd);
    @(posedge clk);
    #1;
    reset      = rst;
    StackWrite = we;
    SP         = sp;
    write_data = wd;
  endtask

  task automatic expect_r1(input string name, input logic [31:0] v);
    exp_t e;
    e.name = name; e.sel2 = 1'b0; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic expect_r2(input string name, input logic [31:0] v);
    exp_t e;
    e.name = name; e.sel2 = 1'b1; e.exp = v;
    sb_q.push_back(e);
  endtask

  initial begin
    // Reset with a simultaneous write that must be discarded.
    cyc(1, 1, 32'd3, 32'hFF);
    cyc(0, 0, 32'd3, 32'h0);
    expect_r1("reset_r1_sp3", 32'h0);
    expect_r2("reset_r2_sp3", 32'h0);

    // Push sequence.
    cyc(0, 1, 32'd1, 32'h7);
    cyc(0, 1, 32'd2, 32'h4);
    cyc(0, 1, 32'd3, 32'h3);
    cyc(0, 0, 32'd4, 32'h0);
    expect_r2("push_r2_sp4", 32'h3);
    expect_r1("push_r1_sp4", 32'h0);
    cyc(0, 0, 32'd2, 32'h0);
    expect_r1("push_r1_sp2", 32'h4);
    expect_r2("push_r2_sp2", 32'h7);

    // No-write hold.
    cyc(0, 0, 32'd4, 32'h0);
    cyc(0, 0, 32'd5, 32'h0);
    expect_r2("hold_r2_sp5", 32'h0);
    expect_r1("hold_r1_sp5", 32'h0);
    cyc(0, 0, 32'd3, 32'h0);
    expect_r1("hold_r1_sp3", 32'h3);
    expect_r2("hold_r2_sp3", 32'h4);

    // SP=0 boundary with mem[63] populated.
    cyc(0, 1, 32'd63, 32'h5);
    cyc(0, 0, 32'd0, 32'h0);
    expect_r2("sp0_r2_forced_zero", 32'h0);
    expect_r1("sp0_r1_mem0", 32'h0);
    cyc(0, 0, 32'd63, 32'h0);
    expect_r1("sp63_r1", 32'h5);

    // Wrap: SP=64 aliases index 0.
    cyc(0, 1, 32'd64, 32'hA);
    cyc(0, 0, 32'd0, 32'h0);
    expect_r1("wrap_r1_sp0", 32'hA);
    cyc(0, 0, 32'd65, 32'h0);
    expect_r2("wrap_r2_sp65", 32'hA);
    expect_r1("wrap_r1_sp65", 32'h7);
    cyc(0, 0, 32'hFFFF_FFFF, 32'h0);
    expect_r1("wrap_r1_spmax", 32'h5);
    expect_r2("wrap_r2_spmax", 32'h0);

    // Same-cycle read of the entry being written.
    cyc(0, 1, 32'd6, 32'h5);
`ifdef STACK_BYPASS_EN
    expect_r1("bypass_r1_sp6", 32'h5);
`else
    expect_r1("nobypass_r1_sp6", 32'h0);
`endif
    expect_r2("bypass_r2_sp6", 32'h0);
    cyc(0, 0, 32'd6, 32'h0);
    expect_r1("after_write_r1_sp6", 32'h5);

    // Reset partway through clears everything.
    cyc(1, 0, 32'd6, 32'h0);
    cyc(0, 0, 32'd6, 32'h0);
    expect_r1("midreset_r1_sp6", 32'h0);
    cyc(0, 0, 32'd2, 32'h0);
    expect_r1("midreset_r1_sp2", 32'h0);
    expect_r2("midreset_r2_sp2", 32'h0);
    cyc(0, 0, 32'd64, 32'h0);
    expect_r1("midreset_r1_sp64", 32'h0);
    expect_r2("midreset_r2_sp64", 32'h0);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
